// File: rtl/boot_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// BootSeqTypes
//
// Shared types for the boot sequencer. Holds the sequencer state encoding,
// the saturation value of the run-cycle counter, and a small helper that
// says which states may start a new program load.
//
// Contents:
//   boot_state_t          3-bit state enum (IDLE=0 .. STEP=5)
//   RUN_CYC_MAX           all-ones value at which run_cycles saturates
//   load_allowed(state)   1 when a load_start pulse is honoured in 'state'
// ---------------------------------------------------------------------------
package BootSeqTypes;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_RUN   = 3'd3,
      ST_HALT  = 3'd4,
      ST_STEP  = 3'd5
   } boot_state_t;

   localparam logic [31:0] RUN_CYC_MAX = 32'hFFFF_FFFF;

   // A reload may abort an idle, running or halted core. Loading, flushing
   // and single-stepping are short, self-terminating states, so a load
   // request arriving there is dropped rather than queued.
   function automatic logic load_allowed(input boot_state_t s);
      return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALT);
   endfunction

endpackage

// File: rtl/boot_sequencer.sv
// ---------------------------------------------------------------------------
// boot_sequencer
//
// Drives a five-stage pipelined core from outside. Streams a program into
// instruction memory over a valid/ready word port, holds the core in reset
// long enough to drain the pipeline, then lets it run. Debug halt,
// single-step, resume and a single PC breakpoint are implemented by gating
// the core's clock enable.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   load_start          pulse: begin a program load
//   load_len[7:0]       words to load, sampled with load_start (0 = rerun)
//   in_valid/in_ready   word handshake; in_data is the program word
//   imem_we/addr/wdata  instruction memory write port (byte address)
//   core_rst            core reset (high in IDLE, LOAD, FLUSH)
//   core_run            core clock enable (high in RUN, STEP)
//   pc_if               core fetch PC, used for the breakpoint
//   bp_en, bp_pc        breakpoint enable and address
//   halt_req, step_req, resume_req   debug pulses
//   halted              state is HALT
//   state_o[2:0]        current state encoding
//   run_cycles[31:0]    saturating count of core_run cycles since last load
// ---------------------------------------------------------------------------
module boot_sequencer
   import BootSeqTypes::*;
#(
   parameter int PC_W       = 9,
   parameter int INS_W      = 32,
   parameter int IMEM_WORDS = 128,
   parameter int FLUSH_CYC  = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              load_start,
   input  logic [7:0]        load_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INS_W-1:0]  in_data,

   output logic              imem_we,
   output logic [PC_W-1:0]   imem_addr,
   output logic [INS_W-1:0]  imem_wdata,

   output logic              core_rst,
   output logic              core_run,
   input  logic [PC_W-1:0]   pc_if,

   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_pc,
   input  logic              halt_req,
   input  logic              step_req,
   input  logic              resume_req,

   output logic              halted,
   output logic [2:0]        state_o,
   output logic [31:0]       run_cycles
);

   // word_cnt indexes words (byte address minus the two zero bits); len
   // needs one extra bit so a full-memory load (IMEM_WORDS) is
   // representable.
   localparam int WC_W  = PC_W - 2;
   localparam int LEN_W = PC_W - 1;
   localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   boot_state_t        state_q,      state_d;
   logic [WC_W-1:0]    word_cnt_q,   word_cnt_d;
   logic [LEN_W-1:0]   len_q,        len_d;
   logic [FC_W-1:0]    flush_cnt_q,  flush_cnt_d;
   logic               bp_mask_q,    bp_mask_d;
   logic [31:0]        run_cycles_q, run_cycles_d;

   logic [LEN_W-1:0]   len_clamped;
   logic               last_word;
   logic               flush_done;
   logic               bp_hit;
   logic               load_accept;

   // Moore outputs decoded from the state register only.
   assign core_rst   = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                       (state_q == ST_FLUSH);
   assign core_run   = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign in_ready   = (state_q == ST_LOAD);
   assign halted     = (state_q == ST_HALT);
   assign state_o    = state_q;
   assign run_cycles = run_cycles_q;

   // The memory write is the handshake itself, so it lands in the same
   // cycle the word is accepted and sustains one word per clock.
   assign imem_we    = in_valid & in_ready;
   assign imem_addr  = {word_cnt_q, 2'b00};
   assign imem_wdata = in_data;

   // Lengths beyond the memory depth are clamped so the word counter can
   // never run past the last word and wrap onto the start of the program.
   always_comb begin
      len_clamped = LEN_W'(load_len);
      if (int'(load_len) > IMEM_WORDS) begin
         len_clamped = LEN_W'(IMEM_WORDS);
      end
   end

   assign last_word   = (LEN_W'(word_cnt_q) == (len_q - LEN_W'(1)));
   assign flush_done  = (flush_cnt_q == FC_W'(FLUSH_CYC - 1));
   assign bp_hit      = bp_en && (pc_if == bp_pc);
   assign load_accept = load_start && load_allowed(state_q);

   // Next-state and counter logic. The per-state case handles normal
   // progress; a reload request is applied afterwards so it overrides
   // whatever the current state would otherwise have done, giving it the
   // highest priority in any state that accepts it.
   always_comb begin
      state_d      = state_q;
      word_cnt_d   = word_cnt_q;
      len_d        = len_q;
      flush_cnt_d  = '0;
      bp_mask_d    = bp_mask_q;
      run_cycles_d = run_cycles_q;

      if (core_run && (run_cycles_q != RUN_CYC_MAX)) begin
         run_cycles_d = run_cycles_q + 32'd1;
      end

      // After a resume or step off a breakpoint, the mask suppresses the
      // hit at that same PC until the core has fetched somewhere else.
      if (core_run && (pc_if != bp_pc)) begin
         bp_mask_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
         end

         ST_LOAD: begin
            if (imem_we) begin
               if (last_word) begin
                  state_d = ST_FLUSH;
               end else begin
                  word_cnt_d = word_cnt_q + WC_W'(1);
               end
            end
         end

         ST_FLUSH: begin
            if (flush_done) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q + FC_W'(1);
            end
         end

         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (bp_hit && !bp_mask_q) begin
               state_d = ST_HALT;
            end
         end

         ST_HALT: begin
            if (resume_req) begin
               state_d   = ST_RUN;
               bp_mask_d = 1'b1;
            end else if (step_req) begin
               state_d   = ST_STEP;
               bp_mask_d = 1'b1;
            end
         end

         ST_STEP: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A zero length reruns the program already in memory, so only the
      // pipeline flush is repeated and the run counter is left alone.
      if (load_accept) begin
         bp_mask_d   = 1'b0;
         flush_cnt_d = '0;
         if (load_len != 8'd0) begin
            state_d      = ST_LOAD;
            len_d        = len_clamped;
            word_cnt_d   = '0;
            run_cycles_d = '0;
         end else begin
            state_d = ST_FLUSH;
         end
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         word_cnt_q   <= '0;
         len_q        <= '0;
         flush_cnt_q  <= '0;
         bp_mask_q    <= 1'b0;
         run_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         len_q        <= len_d;
         flush_cnt_q  <= flush_cnt_d;
         bp_mask_q    <= bp_mask_d;
         run_cycles_q <= run_cycles_d;
      end
   end

endmodule

// File: tb/tb_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_boot_sequencer
//
// Directed self-checking bench for boot_sequencer. Each scenario task drives
// its own stimulus and compares outputs against hand-computed values. Inputs
// change 1 ns after the rising edge; outputs are checked shortly afterwards,
// well away from the next edge.
// ---------------------------------------------------------------------------
module tb_boot_sequencer;

   localparam int PC_W  = 9;
   localparam int INS_W = 32;

   logic              clk;
   logic              rst;
   logic              load_start;
   logic [7:0]        load_len;
   logic              in_valid;
   logic              in_ready;
   logic [INS_W-1:0]  in_data;
   logic              imem_we;
   logic [PC_W-1:0]   imem_addr;
   logic [INS_W-1:0]  imem_wdata;
   logic              core_rst;
   logic              core_run;
   logic [PC_W-1:0]   pc_if;
   logic              bp_en;
   logic [PC_W-1:0]   bp_pc;
   logic              halt_req;
   logic              step_req;
   logic              resume_req;
   logic              halted;
   logic [2:0]        state_o;
   logic [31:0]       run_cycles;

   int vectors;
   int miscompares;

   boot_sequencer #(
      .PC_W       (9),
      .INS_W      (32),
      .IMEM_WORDS (128),
      .FLUSH_CYC  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_len   (load_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .core_run   (core_run),
      .pc_if      (pc_if),
      .bp_en      (bp_en),
      .bp_pc      (bp_pc),
      .halt_req   (halt_req),
      .step_req   (step_req),
      .resume_req (resume_req),
      .halted     (halted),
      .state_o    (state_o),
      .run_cycles (run_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      vectors++; if (state_o !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
      vectors++; if (core_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_core_rst: got %b want 1", core_rst); end
      vectors++; if (core_run !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_core_run: got %b want 0", core_run); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
      vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_imem_we: got %b want 0", imem_we); end
      vectors++; if (imem_addr !== 9'h000) begin miscompares++; $display("[TB] FAIL reset_imem_addr: got %h want 000", imem_addr); end
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
      vectors++; if (run_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_run_cycles: got %0d want 0", run_cycles); end
      rst = 1'b0;
      tick();
   endtask

   // Three words back to back; core_rst must drop four cycles after the
   // third word is accepted.
   task automatic test_load_back_to_back();
      logic [31:0] words [3];
      words[0] = 32'h0050_0093;
      words[1] = 32'h00A0_0113;
      words[2] = 32'h0020_81B3;
      load_start = 1'b1;
      load_len   = 8'd3;
      tick();
      load_start = 1'b0;
      vectors++; if (state_o !== 3'd1 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_enter_load: got state %0d ready %b want 1/1", state_o, in_ready); end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = words[i];
         #1;
         vectors++; if (imem_we !== 1'b1 || imem_addr !== 9'(i * 4) || imem_wdata !== words[i]) begin
            miscompares++;
            $display("[TB] FAIL b2b_write%0d: got we %b addr %h data %h want 1 %h %h", i, imem_we, imem_addr, imem_wdata, 9'(i * 4), words[i]);
         end
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (state_o !== 3'd2 || core_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_flush%0d: got state %0d core_rst %b want 2/1", i, state_o, core_rst); end
         tick();
      end
      vectors++; if (state_o !== 3'd3 || core_rst !== 1'b0 || core_run !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_run: got state %0d core_rst %b core_run %b want 3/0/1", state_o, core_rst, core_run);
      end
      tick();
      tick();
      vectors++; if (run_cycles !== 32'd2) begin miscompares++; $display("[TB] FAIL b2b_run_cycles: got %0d want 2", run_cycles); end
   endtask

   // Reload from RUN with in_valid toggling; only handshaken words write.
   task automatic test_load_gappy();
      load_start = 1'b1;
      load_len   = 8'd2;
      tick();
      load_start = 1'b0;
      vectors++; if (state_o !== 3'd1 || run_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL gappy_enter: got state %0d run_cycles %0d want 1/0", state_o, run_cycles); end
      in_valid = 1'b1; in_data = 32'hAAAA_0001; #1;
      vectors++; if (imem_we !== 1'b1 || imem_addr !== 9'h000) begin miscompares++; $display("[TB] FAIL gappy_w0: got we %b addr %h want 1 000", imem_we, imem_addr); end
      tick();
      in_valid = 1'b0; in_data = 32'hDEAD_BEEF; #1;
      vectors++; if (imem_we !== 1'b0 || state_o !== 3'd1) begin miscompares++; $display("[TB] FAIL gappy_idle: got we %b state %0d want 0/1", imem_we, state_o); end
      tick();
      in_valid = 1'b1; in_data = 32'hAAAA_0002; #1;
      vectors++; if (imem_we !== 1'b1 || imem_addr !== 9'h004 || imem_wdata !== 32'hAAAA_0002) begin
         miscompares++;
         $display("[TB] FAIL gappy_w1: got we %b addr %h data %h want 1 004 aaaa0002", imem_we, imem_addr, imem_wdata);
      end
      tick();
      #1;
      vectors++; if (state_o !== 3'd2 || imem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL gappy_done: got state %0d we %b want 2/0", state_o, imem_we); end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      vectors++; if (state_o !== 3'd3 || run_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL gappy_run: got state %0d run_cycles %0d want 3/0", state_o, run_cycles); end
   endtask

   // Breakpoint at 0x010: halt, resume past it, then hit it again on refetch.
   task automatic test_breakpoint();
      bp_en = 1'b1;
      bp_pc = 9'h010;
      pc_if = 9'h008; tick();
      pc_if = 9'h00C; tick();
      pc_if = 9'h010; #1;
      vectors++; if (state_o !== 3'd3) begin miscompares++; $display("[TB] FAIL bp_before: got state %0d want 3", state_o); end
      tick();
      vectors++; if (state_o !== 3'd4 || halted !== 1'b1 || core_run !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_halt: got state %0d halted %b core_run %b want 4/1/0", state_o, halted, core_run);
      end
      vectors++; if (run_cycles !== 32'd3) begin miscompares++; $display("[TB] FAIL bp_run_cycles: got %0d want 3", run_cycles); end
      resume_req = 1'b1;
      tick();
      resume_req = 1'b0;
      vectors++; if (state_o !== 3'd3) begin miscompares++; $display("[TB] FAIL bp_resume: got state %0d want 3", state_o); end
      tick();
      vectors++; if (state_o !== 3'd3) begin miscompares++; $display("[TB] FAIL bp_masked: got state %0d want 3", state_o); end
      pc_if = 9'h014; tick();
      pc_if = 9'h018; tick();
      pc_if = 9'h010; #1;
      vectors++; if (state_o !== 3'd3) begin miscompares++; $display("[TB] FAIL bp_past: got state %0d want 3", state_o); end
      tick();
      vectors++; if (state_o !== 3'd4 || run_cycles !== 32'd7) begin
         miscompares++;
         $display("[TB] FAIL bp_rehit: got state %0d run_cycles %0d want 4/7", state_o, run_cycles);
      end
   endtask

   // Three spaced single steps, then resume and an explicit halt.
   task automatic test_step_halt();
      pc_if = 9'h020;
      for (int i = 0; i < 3; i++) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         vectors++; if (state_o !== 3'd5 || core_run !== 1'b1) begin miscompares++; $display("[TB] FAIL step%0d_active: got state %0d core_run %b want 5/1", i, state_o, core_run); end
         tick();
         vectors++; if (halted !== 1'b1 || core_run !== 1'b0) begin miscompares++; $display("[TB] FAIL step%0d_back: got halted %b core_run %b want 1/0", i, halted, core_run); end
         tick();
         vectors++; if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL step%0d_hold: got halted %b want 1", i, halted); end
      end
      vectors++; if (run_cycles !== 32'd10) begin miscompares++; $display("[TB] FAIL step_run_cycles: got %0d want 10", run_cycles); end
      resume_req = 1'b1;
      step_req   = 1'b1;
      tick();
      resume_req = 1'b0;
      step_req   = 1'b0;
      vectors++; if (state_o !== 3'd3) begin miscompares++; $display("[TB] FAIL resume_priority: got state %0d want 3", state_o); end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      vectors++; if (state_o !== 3'd4 || core_run !== 1'b0 || run_cycles !== 32'd11) begin
         miscompares++;
         $display("[TB] FAIL halt_req: got state %0d core_run %b run_cycles %0d want 4/0/11", state_o, core_run, run_cycles);
      end
   endtask

   // load_len=200 clamps to 128 words; load_start is ignored in FLUSH.
   task automatic test_clamp();
      load_start = 1'b1;
      load_len   = 8'd200;
      tick();
      load_start = 1'b0;
      vectors++; if (state_o !== 3'd1 || run_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL clamp_enter: got state %0d run_cycles %0d want 1/0", state_o, run_cycles); end
      for (int i = 0; i < 128; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h1000_0000 + 32'(i);
         #1;
         vectors++; if (imem_we !== 1'b1 || imem_addr !== 9'(i * 4) || state_o !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL clamp_w%0d: got we %b addr %h state %0d want 1 %h 1", i, imem_we, imem_addr, state_o, 9'(i * 4));
         end
         tick();
      end
      #1;
      vectors++; if (state_o !== 3'd2 || imem_we !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL clamp_flush: got state %0d we %b ready %b want 2/0/0", state_o, imem_we, in_ready);
      end
      in_valid   = 1'b0;
      load_start = 1'b1;
      load_len   = 8'd3;
      tick();
      load_start = 1'b0;
      vectors++; if (state_o !== 3'd2) begin miscompares++; $display("[TB] FAIL flush_ignores_load: got state %0d want 2", state_o); end
      for (int i = 0; i < 3; i++) tick();
      vectors++; if (state_o !== 3'd3) begin miscompares++; $display("[TB] FAIL clamp_run: got state %0d want 3", state_o); end
   endtask

   // Reset after the 2nd of 5 words abandons the load.
   task automatic test_reset_mid_load();
      load_start = 1'b1;
      load_len   = 8'd5;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h5555_0000 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      vectors++; if (state_o !== 3'd0 || in_ready !== 1'b0 || core_rst !== 1'b1 || run_cycles !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL midload_reset: got state %0d ready %b core_rst %b run_cycles %0d want 0/0/1/0", state_o, in_ready, core_rst, run_cycles);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL midload_nowrite%0d: got we %b want 0", i, imem_we); end
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      load_start  = 1'b0;
      load_len    = 8'd0;
      in_valid    = 1'b0;
      in_data     = '0;
      pc_if       = 9'h100;
      bp_en       = 1'b0;
      bp_pc       = 9'h000;
      halt_req    = 1'b0;
      step_req    = 1'b0;
      resume_req  = 1'b0;

      test_reset();
      test_load_back_to_back();
      test_load_gappy();
      test_breakpoint();
      test_step_halt();
      test_clamp();
      test_reset_mid_load();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Sequences the five-stage pipelined core from outside: streams a program into instruction memory over a valid/ready word port, holds the core in reset long enough to drain the pipeline, then releases it to run. Provides debug halt, single-step, resume and one PC breakpoint by gating the core's clock enable. Sits between the testbench or host loader and the core's `rst`, clock-enable and instruction-memory write port.

## Interface
- `PC_W`, 9, byte-address width of the PC and instruction memory
- `INS_W`, 32, instruction word width
- `IMEM_WORDS`, 128, instruction memory depth in words (2^(PC_W-2))
- `FLUSH_CYC`, 4, cycles `core_rst` is held after loading; must be ≥1
- `clk` in 1: clock
- `rst` in 1: one clock; reset is synchronous and active-high
- `load_start` in 1: begin a new program load (pulse)
- `load_len` in 8: number of words to load, sampled with `load_start`
- `in_valid` in 1: `in_data` holds a program word
- `in_ready` out 1: sequencer accepts a word this cycle
- `in_data` in INS_W: program word
- `imem_we` out 1: instruction memory write strobe
- `imem_addr` out PC_W: byte address of the write, word aligned
- `imem_wdata` out INS_W: write data
- `core_rst` out 1: drives core `rst`
- `core_run` out 1: core clock enable; PC and pipeline registers advance only when high
- `pc_if` in PC_W: core fetch PC
- `bp_en` in 1, `bp_pc` in PC_W: breakpoint enable and address
- `halt_req`, `step_req`, `resume_req` in 1 each: debug controls (pulses)
- `halted` out 1: state is HALT
- `state_o` out 3: current state encoding
- `run_cycles` out 32: count of cycles with `core_run`=1 since the last load

## Operation
- States: IDLE=0, LOAD=1, FLUSH=2, RUN=3, HALT=4, STEP=5.
- `core_rst` = 1 in IDLE, LOAD, FLUSH; 0 otherwise. `core_run` = 1 in RUN, STEP. `in_ready` = 1 only in LOAD. All Moore outputs are decoded from the state register.
- `imem_we` = `in_valid & in_ready`, combinational. `imem_addr` = {word_cnt, 2'b00}. `imem_wdata` = `in_data`.
- IDLE: `load_start` with `load_len`≠0 → LOAD. Latches len = min(`load_len`, IMEM_WORDS) and clears word_cnt and `run_cycles`. `load_start` with `load_len`=0 → FLUSH; memory contents are retained.
- LOAD: each accepted word increments word_cnt. Acceptance of word len−1 → FLUSH; word_cnt never wraps. `in_valid` low leaves the state unchanged, with no timeout.
- FLUSH: flush counter runs FLUSH_CYC cycles, then → RUN.
- RUN: `halt_req` → HALT. `bp_en & (pc_if==bp_pc)` → HALT, unless the bp-mask flag is set.
- HALT: `step_req` → STEP. `resume_req` → RUN. Both set the bp-mask flag.
- STEP: always → HALT after one cycle. The bp-mask flag clears on any RUN or STEP cycle in which `pc_if`≠`bp_pc`.
- `load_start` is accepted in IDLE, RUN and HALT (abort and reload). It is ignored in LOAD, FLUSH and STEP.
- Priority within a cycle: `load_start` > `halt_req` > breakpoint. In HALT, `resume_req` > `step_req`.
- `run_cycles` increments when `core_run`=1 and saturates at 2^32−1.

## Timing
- Reset (synchronous, `rst`=1 at a clock edge) gives: state IDLE, `core_rst`=1, `core_run`=0, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `halted`=0, `state_o`=0, `run_cycles`=0, word_cnt=0, flush counter=0, bp-mask=0. Reset mid-LOAD abandons the load and performs no further writes.
- The write happens in the same cycle as the handshake. Throughput is 1 word per cycle.
- Minimum latency from `load_start` to first RUN cycle: 1 + len + FLUSH_CYC cycles.
- Halt takes effect at the next edge: `core_run` is low in the cycle after `halt_req` is sampled, so the core performs zero further advances.
- STEP gives exactly one `core_run`=1 cycle per `step_req`.

## Structure
- State enum (`boot_state_t`, 3 bits) and the encodings above go in a shared package `BootSeqTypes`, alongside the pipeline register package.
- Single module; the counters and FSM are inline and no sub-module is needed.

## Test plan
- Reset, then `load_start`, `load_len`=3, words 0x00500093/0x00A00113/0x002081B3 back-to-back → writes to 0x000/0x004/0x008, `core_rst` falls 4 cycles after the third word, RUN.
- LOAD with `in_valid` toggled every other cycle, len=2 → exactly 2 writes, `imem_addr` 0x000 then 0x004, no write while `in_valid`=0.
- RUN with `bp_en`=1, `bp_pc`=0x010 → HALT the cycle after `pc_if`=0x010. `resume_req` → runs past 0x010 without re-halting; the breakpoint triggers again when 0x010 is refetched later.
- HALT, 3× `step_req` spaced apart → `run_cycles` increases by exactly 3, `halted` high between steps.
- `load_len`=200 → clamped to 128 words, last write at 0x1FC, then FLUSH.
- `rst` asserted after the 2nd of 5 words → IDLE, `in_ready`=0, `core_rst`=1, `run_cycles`=0, no further `imem_we`.
